systolic_feeder: RTL and testbench

- Operand feeder sitting directly upstream of the 4x4 systolic_array top.
- Buffers one NxN A matrix and one NxN B matrix written row-by-row, then on start streams them diagonally skewed onto a1..aN (rows of A) and b1..bN (columns of B).
- Tracks array drain time and reports completion so downstream logic can sample the array's c outputs.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/skew_select.sv | 36 +++
 rtl/systolic_feeder.sv | 137 +++++++++++++
 tb/tb_systolic_feeder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing for the systolic-array operand feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

  localparam int N          = 4;
  localparam int DW         = 16;
  localparam int FEED_STEPS = 3*N - 2;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/skew_select.sv
// Picks the N elements of one buffered matrix that belong to skew step t, zero-padded.
// Latency: combinational.
// Backpressure: none; a pure function of t and the buffer.
//
// Ports:
//   t    - skew step
//   mat  - NxN matrix, element [r][c] at bits ((r*N)+c)*DW +: DW
//   skew - element i at bits i*DW +: DW
//          COL_MAJOR=0 : skew[i] = mat[i][t-i]  (rows of A feed a1..aN)
//          COL_MAJOR=1 : skew[i] = mat[t-i][i]  (columns of B feed b1..bN)
module skew_select #(
  parameter int N         = 4,
  parameter int DW        = 16,
  parameter int TW        = 4,
  parameter int COL_MAJOR = 0
) (
  input  logic [TW-1:0]     t,
  input  logic [N*N*DW-1:0] mat,
  output logic [N*DW-1:0]   skew
);

  always_comb begin
    skew = '0;
    for (int i = 0; i < N; i++) begin
      // lane i sees element t-i of its row/column; outside 0..N-1 it is padding
      if ((int'(t) >= i) && (int'(t) - i < N)) begin
        if (COL_MAJOR == 0) begin
          skew[i*DW +: DW] = mat[(i*N + int'(t) - i)*DW +: DW];
        end else begin
          skew[i*DW +: DW] = mat[((int'(t) - i)*N + i)*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one NxN A and one NxN B matrix, then streams them diagonally skewed into the array.
// Latency: first skew step registered at the start edge; done pulses 3N-2+DRAIN_CYC edges later.
// Backpressure: none; start and ld_en are ignored (dropped, not queued) while busy.
//
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   ld_en/ld_sel    - write one row of A (ld_sel=0) or B (ld_sel=1)
//   ld_row/ld_data  - row index and row contents, element k at bits k*DW +: DW
//   start           - launch one feed sequence
//   busy, done      - sequence in progress / one-cycle completion pulse
//   a_out, b_out    - skewed operands to array inputs a1..aN, b1..bN
module systolic_feeder #(
  parameter int N         = systolic_pkg::N,
  parameter int DW        = systolic_pkg::DW,
  parameter int DRAIN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en,
  input  logic                 ld_sel,
  input  logic [$clog2(N)-1:0] ld_row,
  input  logic [N*DW-1:0]      ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N*DW-1:0]      a_out,
  output logic [N*DW-1:0]      b_out
);

  import systolic_pkg::*;

  localparam int STEPS = 3*N - 2;
  localparam int CW    = $clog2(3*N - 1);
  localparam int DCW   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t              state;
  logic [CW-1:0]       cnt;       // next skew step to register while in FEED
  logic [CW-1:0]       step_sel;
  logic [DCW-1:0]      dcnt;
  logic [N*N*DW-1:0]   a_buf;
  logic [N*N*DW-1:0]   b_buf;
  logic [N*DW-1:0]     a_skew;
  logic [N*DW-1:0]     b_skew;

  // In IDLE the selectors already present step 0 so the start edge registers it.
  assign step_sel = (state == FEED) ? cnt : '0;

  skew_select #(.N(N), .DW(DW), .TW(CW), .COL_MAJOR(0)) u_skew_a (
    .t    (step_sel),
    .mat  (a_buf),
    .skew (a_skew)
  );

  skew_select #(.N(N), .DW(DW), .TW(CW), .COL_MAJOR(1)) u_skew_b (
    .t    (step_sel),
    .mat  (b_buf),
    .skew (b_skew)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_out <= '0;
      b_out <= '0;
      a_buf <= '0;
      b_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // start wins over a coincident load: the old contents are streamed
            state <= FEED;
            busy  <= 1'b1;
            cnt   <= CW'(1);
            a_out <= a_skew;
            b_out <= b_skew;
          end else if (ld_en) begin
            if (ld_sel) begin
              b_buf[int'(ld_row)*N*DW +: N*DW] <= ld_data;
            end else begin
              a_buf[int'(ld_row)*N*DW +: N*DW] <= ld_data;
            end
          end
        end

        FEED: begin
          if (cnt == CW'(STEPS)) begin
            // counter holds at its terminal value; outputs fall back to zero
            a_out <= '0;
            b_out <= '0;
            dcnt  <= '0;
            if (DRAIN_CYC == 0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt   <= cnt + CW'(1);
            a_out <= a_skew;
            b_out <= b_skew;
          end
        end

        DRAIN: begin
          if (dcnt == DCW'(DRAIN_CYC - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= '0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          a_out <= '0;
          b_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder with a behavioural array model.
// Latency: n/a.
// Backpressure: n/a.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk;
  logic            rst;
  logic            ld_en;
  logic            ld_sel;
  logic [1:0]      ld_row;
  logic [N*DW-1:0] ld_data;
  logic            start;
  logic            busy;
  logic            done;
  logic [N*DW-1:0] a_out;
  logic [N*DW-1:0] b_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] am [N][N];
  logic [DW-1:0] bm [N][N];

  logic [N*DW-1:0] snap_a0, snap_b0, snap_a3, snap_b3;

  // behavioural array: PE(i,j) sees a_out[i] delayed j cycles and b_out[j] delayed i cycles
  logic clr_c;
  int   ah [N][N];
  int   bh [N][N];
  int   c_acc [N][N];

  systolic_feeder #(.N(N), .DW(DW), .DRAIN_CYC(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (ld_en),
    .ld_sel  (ld_sel),
    .ld_row  (ld_row),
    .ld_data (ld_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .a_out   (a_out),
    .b_out   (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_c) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ah[i][j]    = 0;
          bh[i][j]    = 0;
          c_acc[i][j] = 0;
        end
    end else begin
      for (int d = N-1; d > 0; d--)
        for (int i = 0; i < N; i++) begin
          ah[d][i] = ah[d-1][i];
          bh[d][i] = bh[d-1][i];
        end
      for (int i = 0; i < N; i++) begin
        ah[0][i] = int'(a_out[i*DW +: DW]);
        bh[0][i] = int'(b_out[i*DW +: DW]);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          c_acc[i][j] += ah[j][i] * bh[i][j];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] exp_a(input int t);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*DW +: DW] = am[i][t-i];
    return r;
  endfunction

  function automatic logic [N*DW-1:0] exp_b(input int t);
    logic [N*DW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*DW +: DW] = bm[t-j][j];
    return r;
  endfunction

  task automatic load_all();
    for (int r = 0; r < N; r++) begin
      for (int s = 0; s < 2; s++) begin
        ld_en  = 1'b1;
        ld_sel = s[0];
        ld_row = r[1:0];
        for (int k = 0; k < N; k++)
          ld_data[k*DW +: DW] = (s == 0) ? am[r][k] : bm[r][k];
        @(negedge clk);
      end
    end
    ld_en = 1'b0;
  endtask

  task automatic clear_model();
    #2 clr_c = 1'b1;
    @(negedge clk);
    #2 clr_c = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; start is seen at the next edge E. Sample k is taken
  // at the negedge after edge E+k. Optionally pokes start/ld_en while busy.
  task automatic run_feed(input string tag, input bit collide);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ld_en = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s busy k=%0d", tag, k), 64'(busy), 64'(k <= 11));
      check($sformatf("%s done k=%0d", tag, k), 64'(done), 64'(k == 11));
      check($sformatf("%s a_out k=%0d", tag, k), a_out, exp_a(k));
      check($sformatf("%s b_out k=%0d", tag, k), b_out, exp_b(k));
      if (k == 0) begin
        snap_a0 = a_out;
        snap_b0 = b_out;
      end
      if (k == 3) begin
        snap_a3 = a_out;
        snap_b3 = b_out;
      end
      if (collide && k == 2) begin
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_sel  = 1'b0;
        ld_row  = 2'd0;
        ld_data = '1;
      end else if (collide && k == 4) begin
        start = 1'b0;
        ld_en = 1'b0;
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    ld_en   = 1'b0;
    ld_sel  = 1'b0;
    ld_row  = '0;
    ld_data = '0;
    start   = 1'b0;
    clr_c   = 1'b0;

    // reset state
    #3;
    check("rst a_out", a_out, 64'h0);
    check("rst b_out", b_out, 64'h0);
    check("rst busy", 64'(busy), 64'h0);
    check("rst done", 64'(done), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // skew pattern: A[i][k] = 16i+k, B[k][j] = 16k+j+256
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = DW'(16*i + k);
        bm[i][k] = DW'(16*i + k + 256);
      end
    load_all();
    run_feed("skew", 1'b0);
    check("skew hand a E+0", snap_a0, 64'h0000_0000_0000_0000);
    check("skew hand b E+0", snap_b0, 64'h0000_0000_0000_0100);
    check("skew hand a E+3", snap_a3, {16'h0030, 16'h0021, 16'h0012, 16'h0003});
    check("skew hand b E+3", snap_b3, {16'h0103, 16'h0112, 16'h0121, 16'h0130});

    // start and ld_en while busy: same timing, same data
    run_feed("busy_collide", 1'b1);

    // ld_en together with start in IDLE: the write is dropped
    ld_en   = 1'b1;
    ld_sel  = 1'b0;
    ld_row  = 2'd1;
    ld_data = '1;
    run_feed("idle_collide", 1'b0);

    // back-to-back: start in the first cycle after done falls
    run_feed("b2b", 1'b0);

    // reset mid-FEED aborts immediately and clears buffers
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre-abort busy", 64'(busy), 64'h1);
    #2 rst = 1'b0;
    #1;
    check("abort a_out", a_out, 64'h0);
    check("abort b_out", b_out, 64'h0);
    check("abort busy", 64'(busy), 64'h0);
    check("abort done", 64'(done), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = '0;
        bm[i][k] = '0;
      end
    run_feed("post_rst", 1'b0);

    // end-to-end: A = identity, B[k][j] = 4k+j+1  ->  C = 1..16
    clear_model();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = (i == k) ? DW'(1) : DW'(0);
        bm[i][k] = DW'(4*i + k + 1);
      end
    load_all();
    run_feed("ident", 1'b0);
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("ident c%0d", i*N + j + 1), 64'(c_acc[i][j]), 64'(i*N + j + 1));

    // end-to-end: A = B = all 2  ->  every c = 16
    clear_model();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = DW'(2);
        bm[i][k] = DW'(2);
      end
    load_all();
    run_feed("twos", 1'b0);
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("twos c%0d", i*N + j + 1), 64'(c_acc[i][j]), 64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
